// File: rtl/vga_text_console_if.sv
// Byte-stream input and write-only bus output of the text console.
// master: the console itself; slave: the byte source / bus sink side.
interface vga_text_console_if;
    logic [7:0]  data_i;
    logic [7:0]  color_i;
    logic        valid_i;
    logic        ready_o;
    logic        req_o;
    logic        write_enable_o;
    logic [3:0]  mem_be_o;
    logic [31:0] addr_o;
    logic [31:0] write_data_o;
    logic [6:0]  cursor_col_o;
    logic [4:0]  cursor_row_o;

    modport master (
        input  data_i, color_i, valid_i,
        output ready_o, req_o, write_enable_o, mem_be_o, addr_o, write_data_o,
        output cursor_col_o, cursor_row_o
    );

    modport slave (
        output data_i, color_i, valid_i,
        input  ready_o, req_o, write_enable_o, mem_be_o, addr_o, write_data_o,
        input  cursor_col_o, cursor_row_o
    );
endinterface

// File: rtl/vga_text_console.sv
// Text console front end: turns a character stream into char-map and
// colour-map writes, tracking a cursor with line wrap and screen clear.
module vga_text_console #(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic                clk_i,
    input  logic                rst_i,
    vga_text_console_if.master  cif
);
    localparam int NWORDS = COLS * ROWS / 4;

    typedef enum logic [2:0] {IDLE, WR_CHAR, WR_COL, CLR_CHAR, CLR_COL} state_t;

    state_t      state, state_nxt;
    logic [6:0]  col;
    logic [4:0]  row;
    logic [4:0]  row_inc;
    logic [7:0]  data_q, color_q;
    logic [9:0]  clr_k;
    logic [11:0] lin;
    logic        accept, is_print, clr_last;

    assign lin      = 12'(row) * 12'(COLS) + 12'(col);
    assign accept   = cif.valid_i && (state == IDLE);
    assign is_print = (cif.data_i >= 8'h20) && (cif.data_i <= 8'h7E);
    assign clr_last = (clr_k == 10'(NWORDS - 1));
    // Row advance wraps to the top; there is no scrolling.
    assign row_inc  = (row == 5'(ROWS - 1)) ? 5'd0 : row + 5'd1;

    assign cif.ready_o        = (state == IDLE);
    assign cif.write_enable_o = cif.req_o;
    assign cif.cursor_col_o   = col;
    assign cif.cursor_row_o   = row;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and bus outputs; bus is all-zero outside request cycles.
    always_comb begin
        state_nxt        = state;
        cif.req_o        = 1'b0;
        cif.mem_be_o     = 4'b0000;
        cif.addr_o       = 32'h0;
        cif.write_data_o = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (is_print)                  state_nxt = WR_CHAR;
                    else if (cif.data_i == 8'h0C)  state_nxt = CLR_CHAR;
                end
            end
            WR_CHAR: begin
                cif.req_o        = 1'b1;
                cif.addr_o       = {18'b0, 2'b00, lin};
                cif.mem_be_o     = 4'b0001 << lin[1:0];
                cif.write_data_o = {4{data_q}};
                state_nxt        = WR_COL;
            end
            WR_COL: begin
                cif.req_o        = 1'b1;
                cif.addr_o       = {18'b0, 2'b01, lin};
                cif.mem_be_o     = 4'b0001 << lin[1:0];
                cif.write_data_o = {4{color_q}};
                state_nxt        = IDLE;
            end
            CLR_CHAR: begin
                cif.req_o        = 1'b1;
                cif.addr_o       = {18'b0, 2'b00, clr_k, 2'b00};
                cif.mem_be_o     = 4'b1111;
                cif.write_data_o = 32'h2020_2020;
                if (clr_last) state_nxt = CLR_COL;
            end
            CLR_COL: begin
                cif.req_o        = 1'b1;
                cif.addr_o       = {18'b0, 2'b01, clr_k, 2'b00};
                cif.mem_be_o     = 4'b1111;
                cif.write_data_o = {4{color_q}};
                if (clr_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Byte latch, cursor movement and clear word counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col     <= '0;
            row     <= '0;
            data_q  <= '0;
            color_q <= '0;
            clr_k   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data_q  <= cif.data_i;
                        color_q <= cif.color_i;
                        clr_k   <= '0;
                        // Control bytes act on the cursor right at accept.
                        case (cif.data_i)
                            8'h0A: begin
                                col <= '0;
                                row <= row_inc;
                            end
                            8'h0D: col <= '0;
                            8'h08: if (col != 7'd0) col <= col - 7'd1;
                            default: ;
                        endcase
                    end
                end
                WR_COL: begin
                    if (col == 7'(COLS - 1)) begin
                        col <= '0;
                        row <= row_inc;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
                CLR_CHAR: clr_k <= clr_last ? 10'd0 : clr_k + 10'd1;
                CLR_COL: begin
                    if (clr_last) begin
                        col <= '0;
                        row <= '0;
                    end else begin
                        clr_k <= clr_k + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_text_console.sv
// Randomized bench for vga_text_console against a cursor/bus-write model.
module tb_vga_text_console;
    localparam int COLS = 80;
    localparam int ROWS = 30;
    localparam int N    = COLS * ROWS / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    int   m_col = 0;
    int   m_row = 0;

    vga_text_console_if cif();

    vga_text_console #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cif   (cif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic chk_cursor(input string tag);
        chk({tag, "_col"}, 32'(cif.cursor_col_o), 32'(m_col));
        chk({tag, "_row"}, 32'(cif.cursor_row_o), 32'(m_row));
    endtask

    task automatic chk_write(input string tag, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] data);
        chk({tag, "_req"},  32'(cif.req_o), 32'd1);
        chk({tag, "_we"},   32'(cif.write_enable_o), 32'd1);
        chk({tag, "_addr"}, cif.addr_o, addr);
        chk({tag, "_be"},   32'(cif.mem_be_o), 32'(be));
        chk({tag, "_data"}, cif.write_data_o, data);
        chk({tag, "_rdy"},  32'(cif.ready_o), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_rdy"},  32'(cif.ready_o), 32'd1);
        chk({tag, "_req"},  32'(cif.req_o), 32'd0);
        chk({tag, "_bus"},  cif.addr_o | cif.write_data_o | 32'(cif.mem_be_o), 32'd0);
    endtask

    // Reference cursor: next cell in reading order, wrapping bottom-right to top-left.
    task automatic model_advance();
        m_col++;
        if (m_col == COLS) begin
            m_col = 0;
            m_row = (m_row + 1) % ROWS;
        end
    endtask

    // Present one byte, wait until it is taken, then check every cycle of its effect.
    task automatic send_byte(input logic [7:0] d, input logic [7:0] c);
        int budget = 0;
        int lin;
        @(negedge clk);
        cif.data_i = d; cif.color_i = c; cif.valid_i = 1'b1;
        while (!cif.ready_o && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 5000) begin
            chk("ready_timeout", 32'd0, 32'd1);
            cif.valid_i = 1'b0;
            return;
        end
        @(negedge clk);
        cif.valid_i = 1'b0;
        if (d >= 8'h20 && d <= 8'h7E) begin
            lin = m_row * COLS + m_col;
            chk_write("chr", 32'(lin), 4'(1 << (lin % 4)), {4{d}});
            @(negedge clk);
            chk_write("clr", 32'h1000 + 32'(lin), 4'(1 << (lin % 4)), {4{c}});
            @(negedge clk);
            model_advance();
            chk_idle("post_chr");
            chk_cursor("post_chr");
        end else if (d == 8'h0C) begin
            for (int k = 0; k < N; k++) begin
                chk_write("wipe_chr", 32'(k * 4), 4'hF, 32'h2020_2020);
                @(negedge clk);
            end
            for (int k = 0; k < N; k++) begin
                chk_write("wipe_clr", 32'h1000 + 32'(k * 4), 4'hF, {4{c}});
                @(negedge clk);
            end
            m_col = 0; m_row = 0;
            chk_idle("post_wipe");
            chk_cursor("post_wipe");
        end else begin
            if (d == 8'h0A) begin
                m_col = 0;
                m_row = (m_row + 1) % ROWS;
            end else if (d == 8'h0D) begin
                m_col = 0;
            end else if (d == 8'h08 && m_col > 0) begin
                m_col--;
            end
            chk_idle("post_ctl");
            chk_cursor("post_ctl");
        end
    endtask

    initial begin
        logic [7:0] b;
        int r;
        cif.data_i = 8'h00; cif.color_i = 8'h00; cif.valid_i = 1'b0;
        #2;
        chk_idle("reset");
        chk_cursor("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 'A' at the origin, then 'Z' at (6,2)
        send_byte(8'h41, 8'h1F);
        send_byte(8'h0D, 8'h00);
        send_byte(8'h0A, 8'h00);
        send_byte(8'h0A, 8'h00);
        for (int i = 0; i < 6; i++) send_byte(8'h2E, 8'h11);
        chk("pos_lin", 32'(m_row * COLS + m_col), 32'd166);
        send_byte(8'h5A, 8'h22);

        // full clear with colour 0x07
        send_byte(8'h0C, 8'h07);

        // newline wrap from the bottom row, then last-cell wrap
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, 8'h00);
        send_byte(8'h0A, 8'h00);
        chk_cursor("nl_wrap");
        for (int i = 0; i < ROWS - 1; i++) send_byte(8'h0A, 8'h00);
        for (int i = 0; i < COLS - 1; i++) send_byte(8'h2D, 8'h33);
        chk("last_lin", 32'(m_row * COLS + m_col), 32'd2399);
        send_byte(8'h78, 8'h44);
        chk("wrap_col", 32'(cif.cursor_col_o), 32'd0);
        chk("wrap_row", 32'(cif.cursor_row_o), 32'd0);

        // back-to-back controls from (5,3) with valid held high
        for (int i = 0; i < 3; i++) send_byte(8'h0A, 8'h00);
        for (int i = 0; i < 5; i++) send_byte(8'h61, 8'h55);
        @(negedge clk);
        cif.data_i = 8'h0D; cif.valid_i = 1'b1;
        chk_idle("b2b0");
        @(negedge clk);
        chk_idle("b2b1");
        chk("b2b1_col", 32'(cif.cursor_col_o), 32'd0);
        cif.data_i = 8'h08;
        @(negedge clk);
        chk_idle("b2b2");
        cif.data_i = 8'h08;
        @(negedge clk);
        cif.valid_i = 1'b0;
        chk_idle("b2b3");
        m_col = 0;
        chk_cursor("b2b_end");

        // randomized mix of printables, controls and junk
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
            else if (r < 78) b = 8'h0A;
            else if (r < 84) b = 8'h0D;
            else if (r < 92) b = 8'h08;
            else if (r < 95) b = 8'($urandom_range(8'h7F, 8'hFF));
            else if (r < 99) begin
                b = 8'($urandom_range(8'h00, 8'h1F));
                if (b == 8'h0C) b = 8'h00;
            end else         b = 8'h0C;
            send_byte(b, 8'($urandom));
        end

        // reset in the middle of a clear
        send_byte(8'h33, 8'h01);
        @(negedge clk);
        cif.data_i = 8'h0C; cif.color_i = 8'h07; cif.valid_i = 1'b1;
        @(negedge clk);
        cif.valid_i = 1'b0;
        repeat (100) @(negedge clk);
        chk_write("mid_wipe", 32'd400, 4'hF, 32'h2020_2020);
        rst = 1'b1;
        #1;
        m_col = 0; m_row = 0;
        chk_idle("rst_mid");
        chk_cursor("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        chk_idle("rst_rel");
        send_byte(8'h42, 8'h0E);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
